// File: rtl/decode_pkg.sv
// Shared types for the decode stage: opcode encoding, instruction field positions,
// the registered control word handed to execute, and the drain/halt state encoding.
package decode_pkg;

  localparam int PC_W   = 5;
  localparam int IR_W   = 13;
  localparam int NREG   = 8;
  localparam int DATA_W = 8;
  localparam int REG_W  = 3;

  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 3;
  localparam int RS2_MSB = 2;
  localparam int RS2_LSB = 0;
  localparam int IMM3_W  = 3;
  localparam int IMM6_W  = 6;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LDI  = 4'd7,
    OP_LD   = 4'd8,
    OP_ST   = 4'd9,
    OP_BEQ  = 4'd10,
    OP_JMP  = 4'd11,
    OP_HALT = 4'd15
  } opcode_e;

  typedef struct packed {
    logic [3:0]        alu_op;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
    logic              we;
    logic              mem_re;
    logic              mem_we;
    logic              branch;
    logic              jump;
    logic [PC_W-1:0]   tgt;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/decode_unit_if.sv
// Fetch-side, execute-side and writeback signals of the decode stage; slave is the decode side.
interface decode_unit_if;

  logic                              in_valid;
  logic                              in_ready;
  logic [decode_pkg::PC_W-1:0]       in_pc;
  logic [decode_pkg::IR_W-1:0]       in_ir;
  logic                              out_valid;
  logic                              out_ready;
  logic [decode_pkg::PC_W-1:0]       out_pc;
  logic [3:0]                        out_alu_op;
  logic [decode_pkg::REG_W-1:0]      out_rd;
  logic [decode_pkg::REG_W-1:0]      out_rs1;
  logic [decode_pkg::REG_W-1:0]      out_rs2;
  logic [decode_pkg::DATA_W-1:0]     out_imm;
  logic                              out_we;
  logic                              out_mem_re;
  logic                              out_mem_we;
  logic                              out_branch;
  logic                              out_jump;
  logic [decode_pkg::PC_W-1:0]       out_tgt;
  logic                              wb_valid;
  logic [decode_pkg::REG_W-1:0]      wb_rd;
  logic                              flush;
  logic                              halted;
  logic                              illegal;

  modport slave (
    input  in_valid, in_pc, in_ir, out_ready, wb_valid, wb_rd, flush,
    output in_ready, out_valid, out_pc, out_alu_op, out_rd, out_rs1, out_rs2, out_imm,
           out_we, out_mem_re, out_mem_we, out_branch, out_jump, out_tgt, halted, illegal
  );

  modport master (
    output in_valid, in_pc, in_ir, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, out_valid, out_pc, out_alu_op, out_rd, out_rs1, out_rs2, out_imm,
           out_we, out_mem_re, out_mem_we, out_branch, out_jump, out_tgt, halted, illegal
  );

endinterface

// File: rtl/decode_logic.sv
// Pure combinational instruction decoder: ir -> control word, source-use flags, halt/illegal.
// HALT and illegal opcodes both come out as an all-zero NOP word.
module decode_logic
  import decode_pkg::*;
(
  input  logic [IR_W-1:0] ir,
  output ctrl_word_t      ctrl,
  output logic            use_rs1,
  output logic            use_rs2,
  output logic            is_halt,
  output logic            is_illegal
);

  logic [3:0]       op;
  logic [REG_W-1:0] rd;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             writes;

  always_comb begin
    op         = ir[OP_MSB:OP_LSB];
    rd         = ir[RD_MSB:RD_LSB];
    rs1        = ir[RS1_MSB:RS1_LSB];
    rs2        = ir[RS2_MSB:RS2_LSB];
    ctrl       = '0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    writes     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;

    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        writes  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ADDI: begin
        writes   = 1'b1;
        use_rs1  = 1'b1;
        ctrl.imm = {{(DATA_W-IMM3_W){ir[IMM3_W-1]}}, ir[IMM3_W-1:0]};
      end
      OP_LDI: begin
        writes   = 1'b1;
        ctrl.imm = {{(DATA_W-IMM6_W){ir[IMM6_W-1]}}, ir[IMM6_W-1:0]};
      end
      OP_LD: begin
        writes      = 1'b1;
        use_rs1     = 1'b1;
        ctrl.mem_re = 1'b1;
      end
      OP_ST: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        ctrl.mem_we = 1'b1;
      end
      OP_BEQ: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        ctrl.branch = 1'b1;
      end
      OP_JMP: begin
        ctrl.jump = 1'b1;
        ctrl.tgt  = ir[PC_W-1:0];
      end
      OP_HALT: is_halt = 1'b1;
      OP_NOP:  ;
      default: is_illegal = 1'b1;
    endcase

    ctrl.alu_op = (is_halt || is_illegal) ? 4'(OP_NOP) : op;
    // Unused register fields are zeroed so the hazard compare can skip R0 uniformly.
    ctrl.rd     = writes  ? rd  : '0;
    ctrl.rs1    = use_rs1 ? rs1 : '0;
    ctrl.rs2    = use_rs2 ? rs2 : '0;
    ctrl.we     = writes && (rd != '0);
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage: 1-cycle registered control word, RAW stall via pending-register scoreboard.
// Output word holds while out_valid & !out_ready; flush kills it; HALT drains then stops.
module decode_unit
  import decode_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  decode_unit_if.slave  bus
);

  ctrl_word_t      dec;
  logic            use_rs1;
  logic            use_rs2;
  logic            dec_halt;
  logic            dec_illegal;

  ctrl_word_t      out_d,       out_q;
  logic [PC_W-1:0] out_pc_d,    out_pc_q;
  logic            out_valid_d, out_valid_q;
  logic [NREG-1:0] pend_d,      pend_q;
  state_e          state_d,     state_q;
  logic            illegal_d,   illegal_q;

  logic            hz_rs1;
  logic            hz_rs2;
  logic            stall;
  logic            issue;
  logic            xfer;
  logic            in_ready;

  decode_logic u_decode_logic (
    .ir         (bus.in_ir),
    .ctrl       (dec),
    .use_rs1    (use_rs1),
    .use_rs2    (use_rs2),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  // A source is busy if already pending or being produced by the word sitting in the output register.
  assign hz_rs1 = use_rs1 && (dec.rs1 != '0) &&
                  (pend_q[dec.rs1] || (out_valid_q && out_q.we && (out_q.rd == dec.rs1)));
  assign hz_rs2 = use_rs2 && (dec.rs2 != '0) &&
                  (pend_q[dec.rs2] || (out_valid_q && out_q.we && (out_q.rd == dec.rs2)));
  assign stall  = hz_rs1 || hz_rs2;

  assign in_ready = (state_q == ST_RUN) && !stall && !bus.flush && (!out_valid_q || bus.out_ready);
  assign xfer     = bus.in_valid && in_ready;
  assign issue    = out_valid_q && bus.out_ready && !bus.flush;

  always_comb begin
    out_d       = out_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    pend_d      = pend_q;
    state_d     = state_q;
    illegal_d   = illegal_q;

    if (xfer) begin
      out_d       = dec;
      out_pc_d    = bus.in_pc;
      out_valid_d = 1'b1;
      if (dec_illegal) illegal_d = 1'b1;
    end else if (issue || bus.flush) begin
      out_valid_d = 1'b0;
    end

    // Clear first so a same-cycle set of the same register wins.
    if (bus.wb_valid && (bus.wb_rd != '0)) pend_d[bus.wb_rd] = 1'b0;
    if (issue && out_q.we)                 pend_d[out_q.rd]  = 1'b1;

    case (state_q)
      ST_RUN:    if (xfer && dec_halt) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.flush)                               state_d = ST_RUN;
        else if (!out_valid_q && (pend_q == '0))     state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= '0;
      state_q     <= ST_RUN;
      illegal_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pc     = out_pc_q;
  assign bus.out_alu_op = out_q.alu_op;
  assign bus.out_rd     = out_q.rd;
  assign bus.out_rs1    = out_q.rs1;
  assign bus.out_rs2    = out_q.rs2;
  assign bus.out_imm    = out_q.imm;
  assign bus.out_we     = out_q.we;
  assign bus.out_mem_re = out_q.mem_re;
  assign bus.out_mem_we = out_q.mem_we;
  assign bus.out_branch = out_q.branch;
  assign bus.out_jump   = out_q.jump;
  assign bus.out_tgt    = out_q.tgt;
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.illegal    = illegal_q;

endmodule
